// File: rtl/bcd_timer_param.sv
// ---------------------------------------------------------------------------
// BcdTimerParam: divider followed by a two-digit BCD timer with a settable
// modulus.
//
// Falling edges of a slow source strobe are counted. Every DIV of them
// produces a one-cycle tick, and each tick moves a modulo-MOD BCD counter up
// or down by one. Several of these blocks can be chained through the carry
// pulse to build stopwatch, clock and countdown chains.
//
// Parameters
//   DIV    source falling edges per counter step (1..65535)
//   counter modulus, given by the modulus parameter (2..100); the count
//          runs from 0 up to one below the modulus
//   DIV_W  divider counter width, derived from DIV
//
// Ports
//   clk         system clock, everything on the rising edge
//   reset_n     asynchronous reset, active low
//   clk_source  source strobe level; its falling edges are counted
//   enable      1 = divider and counter run, 0 = both hold
//   up_down     1 = count up, 0 = count down
//   load        synchronous load of load_bcd10/load_bcd1
//   load_bcd1   units digit to load
//   load_bcd10  tens digit to load
//   clear       synchronous clear, wins over load
//   bcd1        units digit
//   bcd10       tens digit
//   tick        one-cycle pulse when the divider wraps
//   carry       one-cycle pulse when the counter wraps in either direction
//   at_zero     combinational, high while the count reads 00
// ---------------------------------------------------------------------------
module bcd_timer_param #(
   parameter int unsigned DIV   = 1000,
   parameter int unsigned MOD   = 60,
   parameter int unsigned DIV_W = $clog2(DIV + 1)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk_source,
   input  logic       enable,
   input  logic       up_down,
   input  logic       load,
   input  logic [3:0] load_bcd1,
   input  logic [3:0] load_bcd10,
   input  logic       clear,
   output logic [3:0] bcd1,
   output logic [3:0] bcd10,
   output logic       tick,
   output logic       carry,
   output logic       at_zero
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [3:0]       MAX_ONES = 4'((MOD - 1) % 10);
   localparam logic [3:0]       MAX_TENS = 4'((MOD - 1) / 10);
   localparam logic [7:0]       MOD_BIN  = 8'(MOD);

   logic             srcSync1_q, srcSync2_q, srcSync3_q;
   logic             srcNedge;
   logic [DIV_W-1:0] divCnt_q, divCnt_d;
   logic             tick_q, tick_d;
   logic             carry_q, carry_d;
   logic [3:0]       bcd1_q, bcd1_d;
   logic [3:0]       bcd10_q, bcd10_d;
   logic [7:0]       loadBin;
   logic             loadValid;
   logic             atMax;
   logic             atZero;

   // The source strobe is asynchronous to clk, so it goes through two
   // synchroniser flops before a third flop delays it by one cycle; the
   // falling edge is then the cycle where the delayed copy is still high
   // and the synchronised copy has already dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         srcSync1_q <= 1'b0;
         srcSync2_q <= 1'b0;
         srcSync3_q <= 1'b0;
      end else begin
         srcSync1_q <= clk_source;
         srcSync2_q <= srcSync1_q;
         srcSync3_q <= srcSync2_q;
      end
   end

   assign srcNedge = srcSync3_q & ~srcSync2_q;

   // A load value is accepted only if both digits are decimal and the value
   // fits below the modulus; anything else falls back to the top count.
   always_comb begin
      loadBin   = 8'(load_bcd10) * 8'd10 + 8'(load_bcd1);
      loadValid = (load_bcd1 <= 4'd9) && (load_bcd10 <= 4'd9) && (loadBin < MOD_BIN);
      atMax     = (bcd10_q == MAX_TENS) && (bcd1_q == MAX_ONES);
      atZero    = (bcd10_q == 4'd0) && (bcd1_q == 4'd0);
   end

   // Next-state logic. Clear beats load, load beats a counter step. The step
   // uses the tick registered on the previous cycle, so it still happens
   // while enable is low; only the divider itself is gated by enable.
   always_comb begin
      divCnt_d = divCnt_q;
      tick_d   = 1'b0;
      carry_d  = 1'b0;
      bcd1_d   = bcd1_q;
      bcd10_d  = bcd10_q;
      if (clear) begin
         divCnt_d = '0;
         bcd1_d   = 4'd0;
         bcd10_d  = 4'd0;
      end else if (load) begin
         divCnt_d = '0;
         bcd1_d   = loadValid ? load_bcd1 : MAX_ONES;
         bcd10_d  = loadValid ? load_bcd10 : MAX_TENS;
      end else begin
         if (enable && srcNedge) begin
            if (divCnt_q == DIV_LAST) begin
               divCnt_d = '0;
               tick_d   = 1'b1;
            end else begin
               divCnt_d = divCnt_q + DIV_W'(1);
            end
         end
         if (tick_q) begin
            if (up_down) begin
               if (atMax) begin
                  bcd1_d  = 4'd0;
                  bcd10_d = 4'd0;
                  carry_d = 1'b1;
               end else if (bcd1_q == 4'd9) begin
                  bcd1_d  = 4'd0;
                  bcd10_d = bcd10_q + 4'd1;
               end else begin
                  bcd1_d  = bcd1_q + 4'd1;
               end
            end else begin
               if (atZero) begin
                  bcd1_d  = MAX_ONES;
                  bcd10_d = MAX_TENS;
                  carry_d = 1'b1;
               end else if (bcd1_q == 4'd0) begin
                  bcd1_d  = 4'd9;
                  bcd10_d = bcd10_q - 4'd1;
               end else begin
                  bcd1_d  = bcd1_q - 4'd1;
               end
            end
         end
      end
   end

   // State register for the divider, the pulses and the two digits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divCnt_q <= '0;
         tick_q   <= 1'b0;
         carry_q  <= 1'b0;
         bcd1_q   <= 4'd0;
         bcd10_q  <= 4'd0;
      end else begin
         divCnt_q <= divCnt_d;
         tick_q   <= tick_d;
         carry_q  <= carry_d;
         bcd1_q   <= bcd1_d;
         bcd10_q  <= bcd10_d;
      end
   end

   // Every output comes straight from a register except at_zero.
   assign bcd1    = bcd1_q;
   assign bcd10   = bcd10_q;
   assign tick    = tick_q;
   assign carry   = carry_q;
   assign at_zero = atZero;

endmodule

// File: tb/tb_bcd_timer_param.sv
// ---------------------------------------------------------------------------
// Testbench for bcd_timer_param. Four instances with different DIV/MOD share
// the same stimulus; a behavioural model keeps each instance's count as a
// plain integer and counts expected tick and carry pulses.
// ---------------------------------------------------------------------------
module tb_bcd_timer_param;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_source;
   logic        enable;
   logic        up_down;
   logic        load;
   logic        clear;
   logic [3:0]  load_bcd1;
   logic [3:0]  load_bcd10;
   logic [15:0] bcd1Bus;
   logic [15:0] bcd10Bus;
   logic [3:0]  tickBus;
   logic [3:0]  carryBus;
   logic [3:0]  atZeroBus;

   int divP[4] = '{4, 1, 2, 3};
   int modP[4] = '{60, 60, 100, 7};
   int val[4];
   int edges[4];
   int expTick[4];
   int expCarry[4];
   int tickCnt[4];
   int carryCnt[4];
   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   bcd_timer_param #(.DIV(4), .MOD(60)) u0 (
      .clk(clk), .reset_n(reset_n), .clk_source(clk_source), .enable(enable),
      .up_down(up_down), .load(load), .load_bcd1(load_bcd1), .load_bcd10(load_bcd10),
      .clear(clear), .bcd1(bcd1Bus[3:0]), .bcd10(bcd10Bus[3:0]), .tick(tickBus[0]),
      .carry(carryBus[0]), .at_zero(atZeroBus[0]));

   bcd_timer_param #(.DIV(1), .MOD(60)) u1 (
      .clk(clk), .reset_n(reset_n), .clk_source(clk_source), .enable(enable),
      .up_down(up_down), .load(load), .load_bcd1(load_bcd1), .load_bcd10(load_bcd10),
      .clear(clear), .bcd1(bcd1Bus[7:4]), .bcd10(bcd10Bus[7:4]), .tick(tickBus[1]),
      .carry(carryBus[1]), .at_zero(atZeroBus[1]));

   bcd_timer_param #(.DIV(2), .MOD(100)) u2 (
      .clk(clk), .reset_n(reset_n), .clk_source(clk_source), .enable(enable),
      .up_down(up_down), .load(load), .load_bcd1(load_bcd1), .load_bcd10(load_bcd10),
      .clear(clear), .bcd1(bcd1Bus[11:8]), .bcd10(bcd10Bus[11:8]), .tick(tickBus[2]),
      .carry(carryBus[2]), .at_zero(atZeroBus[2]));

   bcd_timer_param #(.DIV(3), .MOD(7)) u3 (
      .clk(clk), .reset_n(reset_n), .clk_source(clk_source), .enable(enable),
      .up_down(up_down), .load(load), .load_bcd1(load_bcd1), .load_bcd10(load_bcd10),
      .clear(clear), .bcd1(bcd1Bus[15:12]), .bcd10(bcd10Bus[15:12]), .tick(tickBus[3]),
      .carry(carryBus[3]), .at_zero(atZeroBus[3]));

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] toBcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [7:0] bcdOf(input int i);
      return {bcd10Bus[i*4 +: 4], bcd1Bus[i*4 +: 4]};
   endfunction

   // Pulse monitor: counts tick/carry cycles and checks that every carry
   // lands together with the wrapped count.
   always @(negedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < 4; i++) begin
            if (tickBus[i]) tickCnt[i]++;
            if (carryBus[i]) begin
               carryCnt[i]++;
               checkOutput($sformatf("u%0d.carryAlign", i), 32'(bcdOf(i)),
                           32'(up_down ? 8'h00 : toBcd(modP[i] - 1)));
            end
         end
      end
   end

   // Reference model: one counted source edge; a wrapped divider steps the
   // count unless the step is discarded by a clear in the same window.
   task automatic modelEdge(input logic en, input logic dir, input logic kill);
      for (int i = 0; i < 4; i++) begin
         if (en) begin
            edges[i]++;
            if (edges[i] == divP[i]) begin
               edges[i] = 0;
               expTick[i]++;
               if (!kill) begin
                  if (dir) begin
                     if (val[i] == modP[i] - 1) begin val[i] = 0; expCarry[i]++; end
                     else val[i]++;
                  end else begin
                     if (val[i] == 0) begin val[i] = modP[i] - 1; expCarry[i]++; end
                     else val[i]--;
                  end
               end
            end
         end
         if (kill) begin
            val[i]   = 0;
            edges[i] = 0;
         end
      end
   endtask

   task automatic modelLoad(input int d10, input int d1);
      int v;
      for (int i = 0; i < 4; i++) begin
         v = d10 * 10 + d1;
         if (d10 > 9 || d1 > 9 || v >= modP[i]) v = modP[i] - 1;
         val[i]   = v;
         edges[i] = 0;
      end
   endtask

   task automatic verify(input string tag);
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("%s.u%0d.bcd", tag, i), 32'(bcdOf(i)), 32'(toBcd(val[i])));
         checkOutput($sformatf("%s.u%0d.atZero", tag, i), 32'(atZeroBus[i]), 32'(val[i] == 0));
         checkOutput($sformatf("%s.u%0d.ticks", tag, i), 32'(tickCnt[i]), 32'(expTick[i]));
         checkOutput($sformatf("%s.u%0d.carries", tag, i), 32'(carryCnt[i]), 32'(expCarry[i]));
      end
   endtask

   // op 0: one source falling edge; 1: load; 2: clear;
   // 3: source edge with clear+load asserted in the cycle the tick is high.
   task automatic applyStimulus(input int op, input logic [3:0] d10, input logic [3:0] d1,
                                input logic en, input logic dir);
      logic expHigh;
      @(negedge clk);
      enable  = en;
      up_down = dir;
      case (op)
         0, 3: begin
            expHigh    = en && (edges[0] + 1 == divP[0]);
            clk_source = 1'b0;
            if (op == 3) begin
               repeat (3) @(negedge clk);
               checkOutput("u0.tickHigh", 32'(tickBus[0]), 32'(expHigh));
               clear      = 1'b1;
               load       = 1'b1;
               load_bcd10 = d10;
               load_bcd1  = d1;
               @(negedge clk);
               clear = 1'b0;
               load  = 1'b0;
               repeat (5) @(negedge clk);
            end else begin
               repeat (8) @(negedge clk);
            end
            clk_source = 1'b1;
            repeat (4) @(negedge clk);
            modelEdge(en, dir, op == 3);
            verify(op == 3 ? "clrLdTick" : "edge");
         end
         1: begin
            load       = 1'b1;
            load_bcd10 = d10;
            load_bcd1  = d1;
            @(negedge clk);
            load = 1'b0;
            repeat (2) @(negedge clk);
            modelLoad(int'(d10), int'(d1));
            verify("load");
         end
         default: begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            repeat (2) @(negedge clk);
            modelLoad(0, 0);
            verify("clear");
         end
      endcase
   endtask

   initial begin
      int t0;
      int c0;
      int r;
      reset_n    = 1'b0;
      clk_source = 1'b1;
      enable     = 1'b0;
      up_down    = 1'b1;
      load       = 1'b0;
      clear      = 1'b0;
      load_bcd1  = 4'd0;
      load_bcd10 = 4'd0;
      for (int i = 0; i < 4; i++) begin
         val[i] = 0; edges[i] = 0; expTick[i] = 0; expCarry[i] = 0;
         tickCnt[i] = 0; carryCnt[i] = 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rst.u%0d.bcd", i), 32'(bcdOf(i)), 32'h0);
         checkOutput($sformatf("rst.u%0d.atZero", i), 32'(atZeroBus[i]), 32'h1);
         checkOutput($sformatf("rst.u%0d.tick", i), 32'(tickBus[i]), 32'h0);
         checkOutput($sformatf("rst.u%0d.carry", i), 32'(carryBus[i]), 32'h0);
      end
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Full up-count lap on the divide-by-4, modulo-60 instance
      $display("[TB] full lap up");
      applyStimulus(2, 4'd0, 4'd0, 1'b1, 1'b1);
      t0 = tickCnt[0];
      c0 = carryCnt[0];
      repeat (240) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("lap.ticks", 32'(tickCnt[0] - t0), 32'd60);
      checkOutput("lap.carries", 32'(carryCnt[0] - c0), 32'd1);
      checkOutput("lap.bcd", 32'(bcdOf(0)), 32'h00);

      // Down from 00 on the divide-by-1 instance
      $display("[TB] down wrap");
      applyStimulus(1, 4'd0, 4'd0, 1'b1, 1'b0);
      c0 = carryCnt[1];
      applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b0);
      checkOutput("down.bcd59", 32'(bcdOf(1)), 32'h59);
      checkOutput("down.carry", 32'(carryCnt[1] - c0), 32'd1);
      applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b0);
      checkOutput("down.bcd58", 32'(bcdOf(1)), 32'h58);
      checkOutput("down.noCarry", 32'(carryCnt[1] - c0), 32'd1);

      // Invalid and valid loads
      $display("[TB] loads");
      applyStimulus(1, 4'd7, 4'd9, 1'b1, 1'b1);
      checkOutput("ld79.bcd", 32'(bcdOf(0)), 32'h59);
      applyStimulus(1, 4'd1, 4'hA, 1'b1, 1'b1);
      checkOutput("ld1A.bcd", 32'(bcdOf(0)), 32'h59);
      applyStimulus(1, 4'd4, 4'd2, 1'b1, 1'b1);
      checkOutput("ld42.bcd", 32'(bcdOf(0)), 32'h42);
      t0 = tickCnt[0];
      repeat (3) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("ld42.noTick", 32'(tickCnt[0] - t0), 32'd0);
      applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("ld42.tick", 32'(tickCnt[0] - t0), 32'd1);
      checkOutput("ld42.bcd43", 32'(bcdOf(0)), 32'h43);

      // Clear and load in the same cycle as a tick, then disabled edges
      $display("[TB] clear/load/tick collision");
      while (edges[0] != 3) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      c0 = carryCnt[0];
      applyStimulus(3, 4'd4, 4'd2, 1'b1, 1'b1);
      checkOutput("coll.bcd", 32'(bcdOf(0)), 32'h00);
      checkOutput("coll.carry", 32'(carryCnt[0] - c0), 32'd0);
      t0 = tickCnt[0];
      repeat (10) applyStimulus(0, 4'd0, 4'd0, 1'b0, 1'b1);
      checkOutput("dis.noTick", 32'(tickCnt[0] - t0), 32'd0);
      checkOutput("dis.bcd", 32'(bcdOf(0)), 32'h00);

      // Modulo-100 wrap up, then reverse direction
      $display("[TB] modulo 100");
      applyStimulus(1, 4'd9, 4'd8, 1'b1, 1'b1);
      c0 = carryCnt[2];
      repeat (4) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("m100.bcd00", 32'(bcdOf(2)), 32'h00);
      checkOutput("m100.carry", 32'(carryCnt[2] - c0), 32'd1);
      repeat (2) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b0);
      checkOutput("m100.bcd99", 32'(bcdOf(2)), 32'h99);
      checkOutput("m100.carry2", 32'(carryCnt[2] - c0), 32'd2);

      // Asynchronous reset in the middle of a count
      $display("[TB] async reset");
      applyStimulus(1, 4'd3, 4'd7, 1'b1, 1'b1);
      repeat (2) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("ar.bcd37", 32'(bcdOf(0)), 32'h37);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ar.u%0d.bcd", i), 32'(bcdOf(i)), 32'h0);
         checkOutput($sformatf("ar.u%0d.atZero", i), 32'(atZeroBus[i]), 32'h1);
         checkOutput($sformatf("ar.u%0d.tick", i), 32'(tickBus[i]), 32'h0);
         checkOutput($sformatf("ar.u%0d.carry", i), 32'(carryBus[i]), 32'h0);
      end
      modelLoad(0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      t0 = tickCnt[0];
      repeat (3) applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("ar.noTick", 32'(tickCnt[0] - t0), 32'd0);
      applyStimulus(0, 4'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("ar.tick", 32'(tickCnt[0] - t0), 32'd1);
      checkOutput("ar.bcd01", 32'(bcdOf(0)), 32'h01);

      // Randomised mix of edges, loads and clears
      $display("[TB] random phase");
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)
            applyStimulus(0, 4'd0, 4'd0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
         else if (r < 8)
            applyStimulus(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b1);
         else if (r == 8)
            applyStimulus(2, 4'd0, 4'd0, 1'b1, 1'b1);
         else
            applyStimulus(3, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/bcd_timer_param.md
Name: bcd_timer_param

Overview:
- Parametrised divider plus two-digit BCD timer. It generalises the fixed ÷10/÷60/÷1000 dividers and the separate up, down, loadable and clearable BCD-60 counters into one block.
- Counts neg-edges of a slow source strobe (e.g. microsecond or millisecond tick), divides them by DIV, and steps a modulo-MOD BCD counter up or down.
- Provides load, clear and enable controls and a cascade carry/borrow pulse.
- Used to build stopwatch, clock and countdown-timer chains.

Parameters:
DIV, 1000, source neg-edges per counter step; legal range 1..65535.
MOD, 60, counter modulus; legal range 2..100; count range 0..MOD-1.
DIV_W, $clog2(DIV+1), divider counter width (derived; do not override).

Ports:
clk  input  1  system clock, all logic on posedge.
reset_n  input  1  asynchronous reset, active low.
clk_source  input  1  source strobe/clock level; its falling edges are counted.
enable  input  1  1 = divider and counter run; 0 = both hold.
up_down  input  1  1 = count up, 0 = count down.
load  input  1  synchronous load request.
load_bcd1  input  4  units digit to load.
load_bcd10  input  4  tens digit to load.
clear  input  1  synchronous clear.
bcd1  output  4  units digit.
bcd10  output  4  tens digit.
tick  output  1  one-cycle pulse when the divider wraps.
carry  output  1  one-cycle pulse when the counter wraps (up: MOD-1→0; down: 0→MOD-1).
at_zero  output  1  combinational, 1 when bcd10==0 and bcd1==0.

Behaviour:
- Reset (reset_n=0, async):
  - Divider count, bcd1, bcd10, tick, carry = 0.
  - Synchroniser flops = 0.
  - at_zero = 1.
- Source edge detection:
  - clk_source passes through a 2-flop synchroniser (s1, s2), then a delay flop s3.
  - src_nedge = s3 & ~s2.
  - Exactly one src_nedge cycle per falling edge; latency 3 clk edges from the falling edge.
- Divider, evaluated per posedge with enable=1 and src_nedge=1:
  - If div_cnt==DIV-1: div_cnt<=0 and tick<=1.
  - Otherwise div_cnt<=div_cnt+1.
  - tick<=0 on every other cycle.
  - DIV=1: every src_nedge yields a tick.
- Counter step, taken on the posedge where the registered tick==1 (one cycle after the divider wrap):
  - Up: value==MOD-1 → 00 and carry<=1; otherwise +1 with BCD adjust (bcd1==9 → bcd1=0, bcd10+1).
  - Down: value==00 → MOD-1 in BCD and carry<=1; otherwise -1 with BCD adjust (bcd1==0 → bcd1=9, bcd10-1).
  - carry<=0 on every other cycle.
- Priority per cycle: clear > load > tick step.
  - clear: bcd=00, div_cnt=0, tick<=0, carry<=0, any pending step discarded.
  - load: bcd=load value, div_cnt=0, pending tick discarded, carry<=0.
  - Invalid load (a digit >9, or value ≥ MOD): load MOD-1 in BCD instead.
- enable=0:
  - div_cnt and bcd hold; src_nedge ignored.
  - A tick already registered still produces its counter step.
  - clear and load still act.
- up_down is sampled on the step cycle; a direction change takes effect on the next step, never mid-step.
- MOD=100: wrap at 99. MOD≤10: bcd10 stays 0.
- All outputs are registered except at_zero.

Test Plan:
1. DIV=4, MOD=60, up, enable=1; 240 source falling edges → 60 ticks; bcd walks 00..59→00; exactly one carry, coincident with the 59→00 step.
2. DIV=1, MOD=60, down from load 00 (load_bcd10=0, load_bcd1=0); one source edge → bcd=59, carry=1 for one cycle; next edge → 58, carry=0.
3. DIV=4, load 7/9 (79 ≥ 60) → bcd=59; load 1/A (digit >9) → bcd=59; load 4/2 → bcd=42, div_cnt=0, first tick after 4 further edges.
4. Same cycle clear=1, load=1, tick=1 → bcd=00, carry=0, div_cnt=0. Then enable=0 for 10 source edges → no tick, bcd stays 00.
5. MOD=100, DIV=2, up from load 9/8 → after 4 edges bcd=00 with one carry; toggle up_down between steps → next step counts down (00→99, carry).
6. Assert reset_n=0 mid-count (bcd=37, div_cnt=2) asynchronously, between clk edges → outputs 0 immediately, at_zero=1; after release the first tick needs DIV full edges.
